// File: rtl/imu_pipeline_pkg.sv
// Shared definitions for the IMU signal pipeline: default sizes and the
// per-channel hysteresis FSM state encoding.
package imu_pipeline_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 3;
    localparam int DEF_DEB_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND_HI = 2'd1,
        ACTIVE  = 2'd2,
        PEND_LO = 2'd3
    } state_t;

endpackage

// File: rtl/hysteresis_event_detector_if.sv
// Bus between the IMU filter stage / host and the hysteresis event detector.
// sample_valid is a one-way strobe with no ready: every cycle it is high, all
// CHANNELS samples in sample_in are consumed on that rising clk edge.
interface hysteresis_event_detector_if
    import imu_pipeline_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEB_W    = DEF_DEB_W
);
    logic                      sample_valid;
    logic [CHANNELS*WIDTH-1:0] sample_in;
    logic [WIDTH-1:0]          thr_high;
    logic [WIDTH-1:0]          thr_low;
    logic [DEB_W-1:0]          debounce_len;
    logic [CHANNELS-1:0]       clear_sticky;
    logic [CHANNELS-1:0]       event_active;
    logic [CHANNELS-1:0]       rise_pulse;
    logic [CHANNELS-1:0]       fall_pulse;
    logic [CHANNELS-1:0]       event_sticky;
    logic                      irq;
    logic [2*CHANNELS-1:0]     dbg_state;

    modport master (
        output sample_valid, sample_in, thr_high, thr_low, debounce_len, clear_sticky,
        input  event_active, rise_pulse, fall_pulse, event_sticky, irq, dbg_state
    );

    modport slave (
        input  sample_valid, sample_in, thr_high, thr_low, debounce_len, clear_sticky,
        output event_active, rise_pulse, fall_pulse, event_sticky, irq, dbg_state
    );

endinterface

// File: rtl/hysteresis_channel.sv
// One axis of the detector: hysteresis FSM with consecutive-sample debounce,
// one-cycle entry/exit pulses and a host-clearable sticky event flag.
module hysteresis_channel
    import imu_pipeline_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEB_W = DEF_DEB_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] thr_high,
    input  logic signed [WIDTH-1:0] thr_low,
    input  logic [DEB_W-1:0]        debounce_len,
    input  logic                    clear_sticky,
    output logic                    event_active,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic                    event_sticky,
    output state_t                  state
);

    localparam logic [DEB_W:0]   ONE_W = {{DEB_W{1'b0}}, 1'b1};
    localparam logic [DEB_W-1:0] CNT_ONE = {{(DEB_W-1){1'b0}}, 1'b1};

    logic [DEB_W-1:0] cnt;
    logic [DEB_W:0]   n_eff;
    logic [DEB_W:0]   cnt_inc;
    logic             is_high;
    logic             is_low;
    logic             n_is_one;
    logic             reached;

    assign is_high  = sample > thr_high;
    assign is_low   = sample < thr_low;
    assign n_eff    = (debounce_len == '0) ? ONE_W : {1'b0, debounce_len};
    assign n_is_one = (n_eff == ONE_W);
    assign cnt_inc  = {1'b0, cnt} + ONE_W;
    // >= rather than == so a debounce_len lowered below cnt fires immediately
    assign reached  = (cnt_inc >= n_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            event_active <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            event_sticky <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            // a rise in this same cycle overrides the clear further down
            if (clear_sticky) begin
                event_sticky <= 1'b0;
            end
            if (sample_valid) begin
                case (state)
                    IDLE: begin
                        if (is_high) begin
                            if (n_is_one) begin
                                state        <= ACTIVE;
                                event_active <= 1'b1;
                                rise_pulse   <= 1'b1;
                                event_sticky <= 1'b1;
                            end else begin
                                state <= PEND_HI;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PEND_HI: begin
                        if (!is_high) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (reached) begin
                            state        <= ACTIVE;
                            cnt          <= '0;
                            event_active <= 1'b1;
                            rise_pulse   <= 1'b1;
                            event_sticky <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[DEB_W-1:0];
                        end
                    end
                    ACTIVE: begin
                        if (is_low) begin
                            if (n_is_one) begin
                                state        <= IDLE;
                                event_active <= 1'b0;
                                fall_pulse   <= 1'b1;
                            end else begin
                                state <= PEND_LO;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PEND_LO: begin
                        if (!is_low) begin
                            state <= ACTIVE;
                            cnt   <= '0;
                        end else if (reached) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            event_active <= 1'b0;
                            fall_pulse   <= 1'b1;
                        end else begin
                            cnt <= cnt_inc[DEB_W-1:0];
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/hysteresis_event_detector.sv
// Multi-axis threshold event detector: one independent hysteresis channel per
// axis, with the sticky event flags ORed into a single interrupt.
module hysteresis_event_detector
    import imu_pipeline_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEB_W    = DEF_DEB_W
) (
    input logic                        clk,
    input logic                        rst_n,
    hysteresis_event_detector_if.slave bus
);

    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] sticky;
    state_t              ch_state [CHANNELS];

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            hysteresis_channel #(
                .WIDTH (WIDTH),
                .DEB_W (DEB_W)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .sample_valid (bus.sample_valid),
                .sample       (bus.sample_in[i*WIDTH +: WIDTH]),
                .thr_high     (bus.thr_high),
                .thr_low      (bus.thr_low),
                .debounce_len (bus.debounce_len),
                .clear_sticky (bus.clear_sticky[i]),
                .event_active (active[i]),
                .rise_pulse   (rise[i]),
                .fall_pulse   (fall[i]),
                .event_sticky (sticky[i]),
                .state        (ch_state[i])
            );
            assign bus.dbg_state[2*i +: 2] = ch_state[i];
        end
    endgenerate

    assign bus.event_active = active;
    assign bus.rise_pulse   = rise;
    assign bus.fall_pulse   = fall;
    assign bus.event_sticky = sticky;
    assign bus.irq          = |sticky;

endmodule

// File: tb/tb_hysteresis_event_detector.sv
// Bench for hysteresis_event_detector: directed scenarios plus random traffic,
// checked against a run-length model of the debounce/hysteresis rules.
module tb_hysteresis_event_detector;
    import imu_pipeline_pkg::*;

    localparam int WIDTH = 16;
    localparam int CH    = 3;
    localparam int DEB_W = 4;
    localparam int EXP_W = 2*CH + 4*CH + 1;

    logic clk;
    logic rst_n;

    hysteresis_event_detector_if #(.WIDTH(WIDTH), .CHANNELS(CH), .DEB_W(DEB_W)) bus ();

    hysteresis_event_detector #(.WIDTH(WIDTH), .CHANNELS(CH), .DEB_W(DEB_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // model: per channel, "in event" flag plus length of current qualifying run
    bit m_ev     [CH];
    int m_run    [CH];
    bit m_rise   [CH];
    bit m_fall   [CH];
    bit m_sticky [CH];
    int cur_th, cur_tl, cur_dl;

    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_ev[c] = 0; m_run[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_sticky[c] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input int s [CH], input logic [CH-1:0] clr);
        int n;
        n = (cur_dl == 0) ? 1 : cur_dl;
        for (int c = 0; c < CH; c++) begin
            m_rise[c] = 0;
            m_fall[c] = 0;
            if (v) begin
                if (!m_ev[c]) begin
                    if (s[c] > cur_th) begin
                        m_run[c]++;
                        if (m_run[c] >= n) begin m_ev[c] = 1; m_rise[c] = 1; m_run[c] = 0; end
                    end else m_run[c] = 0;
                end else begin
                    if (s[c] < cur_tl) begin
                        m_run[c]++;
                        if (m_run[c] >= n) begin m_ev[c] = 0; m_fall[c] = 1; m_run[c] = 0; end
                    end else m_run[c] = 0;
                end
            end
            if (clr[c]) m_sticky[c] = 0;
            if (m_rise[c]) m_sticky[c] = 1;
        end
    endtask

    // scoreboard: push model expectation, pop and compare against DUT
    task automatic compare_all();
        logic [EXP_W-1:0] e;
        logic [2*CH-1:0] e_st;
        logic [CH-1:0] e_act, e_rise, e_fall, e_stk;
        for (int c = 0; c < CH; c++) begin
            e_st[2*c +: 2] = m_ev[c] ? ((m_run[c] > 0) ? 2'd3 : 2'd2) : ((m_run[c] > 0) ? 2'd1 : 2'd0);
            e_act[c]  = m_ev[c];
            e_rise[c] = m_rise[c];
            e_fall[c] = m_fall[c];
            e_stk[c]  = m_sticky[c];
        end
        exp_q.push_back({e_st, e_act, e_rise, e_fall, e_stk, |e_stk});
        e = exp_q.pop_front();
        check("state",  32'(bus.dbg_state),    32'(e[EXP_W-1 -: 2*CH]));
        check("active", 32'(bus.event_active), 32'(e[4*CH -: CH]));
        check("rise",   32'(bus.rise_pulse),   32'(e[3*CH -: CH]));
        check("fall",   32'(bus.fall_pulse),   32'(e[2*CH -: CH]));
        check("sticky", 32'(bus.event_sticky), 32'(e[CH -: CH]));
        check("irq",    32'(bus.irq),          32'(e[0]));
    endtask

    task automatic set_cfg(input int th, input int tl, input int dl);
        cur_th = th; cur_tl = tl; cur_dl = dl;
        bus.thr_high     = 16'(th);
        bus.thr_low      = 16'(tl);
        bus.debounce_len = 4'(dl);
    endtask

    // driver: present one cycle of inputs, clock it, then check
    task automatic step(input bit v, input int s0, input int s1, input int s2,
                        input logic [CH-1:0] clr = '0);
        int s [CH];
        s[0] = s0; s[1] = s1; s[2] = s2;
        bus.sample_valid = v;
        bus.sample_in    = {16'(s2), 16'(s1), 16'(s0)};
        bus.clear_sticky = clr;
        @(posedge clk);
        model_edge(v, s, clr);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.clear_sticky = '0;
        set_cfg(100, 80, 3);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("rst_irq", 32'(bus.irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // hysteresis band on ch0
        step(1, 50, 0, 0);
        step(1, 101, 0, 0);
        step(1, 101, 0, 0);
        step(1, 101, 0, 0);
        check("hys_rise3", 32'(bus.rise_pulse[0]), 32'd1);
        step(1, 90, 0, 0);
        check("hys_rise_once", 32'(bus.rise_pulse[0]), 32'd0);
        step(1, 90, 0, 0);
        check("hys_band_active", 32'(bus.event_active[0]), 32'd1);
        step(1, 79, 0, 0);
        step(1, 79, 0, 0);
        step(1, 79, 0, 0);
        check("hys_fall3", 32'(bus.fall_pulse[0]), 32'd1);
        check("hys_exit", 32'(bus.event_active[0]), 32'd0);

        // debounce reject on ch1
        step(1, 0, 101, 0);
        step(1, 0, 101, 0);
        step(1, 0, 50, 0);
        check("deb_idle", 32'(bus.dbg_state[3:2]), 32'(IDLE));
        step(1, 0, 101, 0);
        step(1, 0, 101, 0);
        check("deb_no_rise", 32'(bus.event_active[1]), 32'd0);
        step(1, 0, 0, 0);

        // valid gaps on ch0
        step(1, 101, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(1, 101, 0, 0);
        step(1, 101, 0, 0);
        check("gap_rise", 32'(bus.rise_pulse[0]), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 79, 0, 0);

        // boundaries: equal to threshold never qualifies
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0);
        check("bnd_hi_eq", 32'(bus.event_active[0]), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 101, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 80, 0, 0);
        check("bnd_lo_eq", 32'(bus.event_active[0]), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 79, 0, 0);
        set_cfg(-100, -120, 3);
        for (int i = 0; i < 3; i++) step(1, -99, -100, -150);
        check("bnd_neg_entry", 32'(bus.event_active), 32'b001);
        for (int i = 0; i < 3; i++) step(1, -121, -100, -150);
        set_cfg(100, 80, 3);

        // sticky and irq on ch2
        step(0, 0, 0, 0, 3'b001);
        check("stk_cleared", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 101);
        check("stk_set", 32'(bus.event_sticky[2]), 32'd1);
        check("stk_irq", 32'(bus.irq), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 79);
        step(1, 0, 0, 101);
        step(1, 0, 0, 101);
        step(1, 0, 0, 101, 3'b100);
        check("stk_set_wins", 32'(bus.event_sticky[2]), 32'd1);
        step(0, 0, 0, 0, 3'b100);
        check("stk_clear", 32'(bus.event_sticky[2]), 32'd0);
        check("stk_irq_low", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 79);

        // asynchronous reset mid-event
        for (int i = 0; i < 3; i++) step(1, 101, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_mid_active", 32'(bus.event_active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        check("rst_no_fall", 32'(bus.fall_pulse), 32'd0);

        // debounce_len = 0 behaves as 1
        set_cfg(100, 80, 0);
        step(1, 101, 0, 0);
        check("deb0_rise", 32'(bus.rise_pulse[0]), 32'd1);
        step(1, 79, 0, 0);
        check("deb0_fall", 32'(bus.fall_pulse[0]), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [CH-1:0] clr;
            if ($urandom_range(15, 0) == 0)
                set_cfg(int'($urandom_range(120, 60)), int'($urandom_range(110, 40)),
                        int'($urandom_range(4, 0)));
            clr = ($urandom_range(9, 0) == 0) ? CH'($urandom_range(7, 0)) : '0;
            step($urandom_range(4, 0) != 0,
                 int'($urandom_range(220, 0)) - 40,
                 int'($urandom_range(220, 0)) - 40,
                 int'($urandom_range(220, 0)) - 40, clr);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
